// File: rtl/decode_exec_unit.sv
// Two-stage decode/execute slice of the 16-bit CPU: stage D decodes and registers
// control fields, stage E reads the register file and registers ALU/branch/memory results.
module decode_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] instr,
    output logic [2:0]  rf_addr_a,
    output logic [2:0]  rf_addr_b,
    input  logic [15:0] rf_data_a,
    input  logic [15:0] rf_data_b,
    output logic        ex_valid,
    output logic [1:0]  ex_class,
    output logic [15:0] ex_result,
    output logic [2:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_wb_sel,
    output logic        ex_mem_write,
    output logic [15:0] ex_store_data,
    output logic        ex_pc_write,
    output logic [15:0] ex_jump_target
);

    typedef enum logic [1:0] {
        CLS_MEM = 2'b00,
        CLS_ALU = 2'b01,
        CLS_JMP = 2'b10,
        CLS_NOP = 2'b11
    } cls_e;

    // ALU op 4'hF falls in the "result 0" range, used for classes that do not compute.
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ZERO = 4'hF;

    typedef struct packed {
        logic        valid;
        cls_e        cls;
        logic [3:0]  alu_op;
        logic        use_imm;
        logic [15:0] imm;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        reg_write;
        logic        wb_sel;
        logic        mem_write;
        logic [2:0]  jump_ctrl;
    } d_stage_t;

    typedef struct packed {
        logic        valid;
        cls_e        cls;
        logic [15:0] result;
        logic [2:0]  rd;
        logic        reg_write;
        logic        wb_sel;
        logic        mem_write;
        logic [15:0] store_data;
        logic        pc_write;
        logic [15:0] jump_target;
    } e_stage_t;

    d_stage_t d_q, d_d;
    e_stage_t e_q, e_d;

    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [4:0]  alu_ctrl;
    logic        jump_taken;

    always_comb begin
        // NOTE: every field gets a default here so no path leaves a latch behind;
        // a bubble therefore decodes to an all-zero D stage.
        d_d = '0;
        if (in_valid) begin
            d_d.valid = 1'b1;
            d_d.cls   = cls_e'(instr[15:14]);
            case (cls_e'(instr[15:14]))
                CLS_ALU: begin
                    d_d.alu_op    = instr[12:9];
                    d_d.rd        = instr[8:6];
                    d_d.reg_write = 1'b1;
                    if (instr[13]) begin
                        d_d.use_imm = 1'b1;
                        d_d.imm     = {{10{instr[5]}}, instr[5:0]};
                        d_d.rs1     = instr[8:6];
                    end else begin
                        d_d.rs1 = instr[5:3];
                        d_d.rs2 = instr[2:0];
                    end
                end
                CLS_MEM: begin
                    d_d.alu_op  = OP_ADD;
                    d_d.use_imm = 1'b1;
                    d_d.imm     = {{13{instr[2]}}, instr[2:0]};
                    d_d.rs1     = instr[5:3];
                    if (instr[13]) begin
                        d_d.rs2       = instr[8:6];
                        d_d.mem_write = 1'b1;
                    end else begin
                        d_d.rd        = instr[8:6];
                        d_d.reg_write = 1'b1;
                        d_d.wb_sel    = 1'b1;
                    end
                end
                CLS_JMP: begin
                    d_d.alu_op    = OP_ZERO;
                    d_d.jump_ctrl = instr[13:11];
                    d_d.rs1       = instr[5:3];
                    d_d.rs2       = instr[2:0];
                end
                default: d_d.alu_op = OP_ZERO;
            endcase
        end
    end

    assign rf_addr_a = d_q.rs1;
    assign rf_addr_b = d_q.rs2;

    assign alu_b    = d_q.use_imm ? d_q.imm : rf_data_b;
    assign alu_ctrl = {1'b0, d_q.alu_op};

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            5'd0:    alu_result = rf_data_a + alu_b;
            5'd1:    alu_result = rf_data_a - alu_b;
            5'd2:    alu_result = rf_data_a & alu_b;
            5'd3:    alu_result = rf_data_a | alu_b;
            5'd4:    alu_result = rf_data_a ^ alu_b;
            5'd5:    alu_result = ~rf_data_a;
            5'd6:    alu_result = rf_data_a << alu_b[3:0];
            5'd7:    alu_result = rf_data_a >> alu_b[3:0];
            5'd8:    alu_result = $signed(rf_data_a) >>> alu_b[3:0];
            5'd9:    alu_result = {15'b0, $signed(rf_data_a) < $signed(alu_b)};
            5'd10:   alu_result = {15'b0, rf_data_a < alu_b};
            5'd11:   alu_result = alu_b;
            default: alu_result = '0;
        endcase
    end

    // Jump test value is rs1, interpreted as signed.
    always_comb begin
        jump_taken = 1'b0;
        case (d_q.jump_ctrl)
            3'd0: jump_taken = 1'b0;
            3'd1: jump_taken = 1'b1;
            3'd2: jump_taken = (rf_data_a == 16'd0);
            3'd3: jump_taken = (rf_data_a != 16'd0);
            3'd4: jump_taken = rf_data_a[15];
            3'd5: jump_taken = !rf_data_a[15] && (rf_data_a != 16'd0);
            3'd6: jump_taken = !rf_data_a[15];
            3'd7: jump_taken = rf_data_a[15] || (rf_data_a == 16'd0);
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        e_d = '0;
        if (d_q.valid) begin
            e_d.valid       = 1'b1;
            e_d.cls         = d_q.cls;
            e_d.result      = alu_result;
            e_d.rd          = d_q.rd;
            e_d.reg_write   = d_q.reg_write;
            e_d.wb_sel      = d_q.wb_sel;
            e_d.mem_write   = d_q.mem_write;
            e_d.store_data  = rf_data_b;
            e_d.pc_write    = (d_q.cls == CLS_JMP) && jump_taken;
            e_d.jump_target = rf_data_b;
        end
    end

    // NOTE: state registers use non-blocking assignments so both stages update
    // from the same pre-edge values, which is what makes this a two-stage pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            e_q <= '0;
        end else begin
            d_q <= d_d;
            e_q <= e_d;
        end
    end

    assign ex_valid       = e_q.valid;
    assign ex_class       = e_q.cls;
    assign ex_result      = e_q.result;
    assign ex_rd          = e_q.rd;
    assign ex_reg_write   = e_q.reg_write;
    assign ex_wb_sel      = e_q.wb_sel;
    assign ex_mem_write   = e_q.mem_write;
    assign ex_store_data  = e_q.store_data;
    assign ex_pc_write    = e_q.pc_write;
    assign ex_jump_target = e_q.jump_target;

endmodule

// File: tb/tb_decode_exec_unit.sv
// Scoreboard bench for decode_exec_unit: a behavioural model predicts each result at issue,
// a monitor compares whatever the E stage presents on every falling edge.
module tb_decode_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] instr;
    logic [2:0]  rf_addr_a, rf_addr_b;
    logic [15:0] rf_data_a, rf_data_b;
    logic        ex_valid;
    logic [1:0]  ex_class;
    logic [15:0] ex_result;
    logic [2:0]  ex_rd;
    logic        ex_reg_write, ex_wb_sel, ex_mem_write, ex_pc_write;
    logic [15:0] ex_store_data, ex_jump_target;

    logic [15:0] rf [8];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  cls;
        logic [15:0] result;
        logic [2:0]  rd;
        logic        reg_write, wb_sel, mem_write, pc_write;
        logic [15:0] store_data, jump_target;
        bit          chk_res, chk_rd, chk_store, chk_jt;
        int          out_cyc;
    } exp_t;

    typedef struct {
        logic [2:0] a, b;
        bit         chk_a, chk_b;
    } addr_t;

    exp_t  sb_q[$];
    addr_t addr_chk[int];

    decode_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .ex_valid(ex_valid), .ex_class(ex_class), .ex_result(ex_result), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .ex_pc_write(ex_pc_write),
        .ex_jump_target(ex_jump_target)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int sval(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic logic [15:0] alu_model(input int op, input logic [15:0] a, input logic [15:0] b);
        int sh = int'(b) % 16;
        case (op)
            0:  return 16'(int'(a) + int'(b));
            1:  return 16'(int'(a) - int'(b));
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~a;
            6:  return 16'(int'(a) * (1 << sh));
            7:  return 16'(int'(a) / (1 << sh));
            8:  return 16'(sval(a) >>> sh);
            9:  return (sval(a) < sval(b)) ? 16'd1 : 16'd0;
            10: return (int'(a) < int'(b)) ? 16'd1 : 16'd0;
            11: return b;
            default: return 16'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [15:0] i, output addr_t ad);
        exp_t e;
        int t, imm;
        e = '{cls: i[15:14], default: '0};
        ad = '{default: '0};
        case (i[15:14])
            2'b01: begin
                e.rd = i[8:6]; e.reg_write = 1'b1; e.chk_res = 1; e.chk_rd = 1;
                if (i[13]) begin
                    imm = i[5] ? int'(i[5:0]) - 64 : int'(i[5:0]);
                    e.result = alu_model(int'(i[12:9]), rf[i[8:6]], 16'(imm));
                    ad = '{a: i[8:6], b: 3'd0, chk_a: 1, chk_b: 1};
                end else begin
                    e.result = alu_model(int'(i[12:9]), rf[i[5:3]], rf[i[2:0]]);
                    ad = '{a: i[5:3], b: i[2:0], chk_a: 1, chk_b: 1};
                end
            end
            2'b00: begin
                imm = i[2] ? int'(i[2:0]) - 8 : int'(i[2:0]);
                e.result = 16'(int'(rf[i[5:3]]) + imm); e.chk_res = 1;
                ad.a = i[5:3]; ad.chk_a = 1;
                if (i[13]) begin
                    e.mem_write = 1'b1; e.store_data = rf[i[8:6]]; e.chk_store = 1;
                    ad.b = i[8:6]; ad.chk_b = 1;
                end else begin
                    e.reg_write = 1'b1; e.wb_sel = 1'b1; e.rd = i[8:6]; e.chk_rd = 1;
                end
            end
            2'b10: begin
                t = sval(rf[i[5:3]]);
                case (int'(i[13:11]))
                    0: e.pc_write = 1'b0;
                    1: e.pc_write = 1'b1;
                    2: e.pc_write = (t == 0);
                    3: e.pc_write = (t != 0);
                    4: e.pc_write = (t < 0);
                    5: e.pc_write = (t > 0);
                    6: e.pc_write = (t >= 0);
                    default: e.pc_write = (t <= 0);
                endcase
                e.jump_target = rf[i[2:0]]; e.chk_jt = 1;
                ad = '{a: i[5:3], b: i[2:0], chk_a: 1, chk_b: 1};
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: compare E-stage outputs against the scoreboard every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ex_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'(ex_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", cyc, e.out_cyc);
                    check("class", 32'(ex_class), 32'(e.cls));
                    check("enables", 32'({ex_reg_write, ex_wb_sel, ex_mem_write, ex_pc_write}),
                          32'({e.reg_write, e.wb_sel, e.mem_write, e.pc_write}));
                    if (e.chk_res)   check("result", 32'(ex_result), 32'(e.result));
                    if (e.chk_rd)    check("rd", 32'(ex_rd), 32'(e.rd));
                    if (e.chk_store) check("store_data", 32'(ex_store_data), 32'(e.store_data));
                    if (e.chk_jt)    check("jump_target", 32'(ex_jump_target), 32'(e.jump_target));
                end
            end else begin
                check("bubble_enables", 32'({ex_reg_write, ex_mem_write, ex_pc_write}), 32'd0);
                check("bubble_data", 32'(ex_result | ex_store_data | ex_jump_target), 32'd0);
                check("bubble_ctrl", 32'({ex_class, ex_rd, ex_wb_sel}), 32'd0);
            end
            if (addr_chk.exists(cyc)) begin
                if (addr_chk[cyc].chk_a) check("rf_addr_a", 32'(rf_addr_a), 32'(addr_chk[cyc].a));
                if (addr_chk[cyc].chk_b) check("rf_addr_b", 32'(rf_addr_b), 32'(addr_chk[cyc].b));
                addr_chk.delete(cyc);
            end
        end
    end

    task automatic issue(input logic [15:0] i, input logic v, input bit track);
        exp_t  e;
        addr_t ad;
        @(negedge clk);
        instr = i;
        in_valid = v;
        if (v && track) begin
            e = model(i, ad);
            e.out_cyc = cyc + 2;
            sb_q.push_back(e);
            addr_chk[cyc + 1] = ad;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) issue(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic run1(input logic [15:0] i);
        issue(i, 1'b1, 1'b1);
        idle(3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_en"}, 32'({ex_valid, ex_reg_write, ex_wb_sel, ex_mem_write, ex_pc_write}), 32'd0);
        check({tag, "_data"}, 32'(ex_result | ex_store_data | ex_jump_target), 32'd0);
        check({tag, "_fields"}, 32'({ex_class, ex_rd, rf_addr_a, rf_addr_b}), 32'd0);
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        int budget;
        rst = 1'b1;
        in_valid = 1'b0;
        instr = '0;
        for (int k = 0; k < 8; k++) rf[k] = '0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        rf[1] = 16'd5; rf[2] = 16'd7;           run1(16'h40CA);  // R-type ADD
        rf[2] = 16'd10;                         run1(16'h62BF);  // I-type SUB imm -1
        rf[2] = 16'hFF00;                       run1(16'h7084);  // SRA by 4
        rf[2] = 16'h8000;                       run1(16'h7281);  // SLT vs 1
                                                run1(16'h7481);  // SLTU vs 1
        rf[1] = 16'h0100; rf[4] = 16'hBEEF;     run1(16'h210E);  // store
                                                run1(16'h010E);  // load
        rf[1] = 16'h0000; rf[2] = 16'h0040;     run1(16'h900A);  // jump if zero, taken
        rf[1] = 16'h0001;                       run1(16'h900A);  // not taken
        rf[1] = 16'h8000;                       run1(16'hA00A);  // T<0, taken
        rf[1] = 16'h0000;                       run1(16'h800A);  // never

        // Back-to-back stream with a bubble in slot 3.
        for (int k = 0; k < 8; k++) rf[k] = pick_val();
        issue(16'h40CA, 1'b1, 1'b1);
        issue(16'h210E, 1'b1, 1'b1);
        issue(16'h0000, 1'b0, 1'b1);
        issue(16'h900A, 1'b1, 1'b1);
        idle(3);

        // Reset with two instructions in flight.
        issue(16'h40CA, 1'b1, 1'b0);
        issue(16'h010E, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        run1(16'h62BF);

        // Randomized traffic; register file re-rolled between drained bursts.
        for (int burst = 0; burst < 8; burst++) begin
            for (int k = 0; k < 8; k++) rf[k] = pick_val();
            for (int n = 0; n < 40; n++)
                issue(16'($urandom()), ($urandom_range(0, 3) != 0), 1'b1);
            idle(3);
        end

        budget = 10;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_exec_unit.md
Name: decode_exec_unit

Overview:
- Two-stage decode/execute slice of the 16-bit pipelined CPU.
- Stage D decodes an instruction word and registers the control and register-address fields.
- Stage E reads operand values from the external register file, then computes the ALU result, branch decision, memory-write controls and write-back controls, and registers them.
- Sits between instruction fetch and the memory/write-back stages. Contains the decoder, the 16-bit ALU and the jump evaluator.

Parameters:
- none

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instr is a valid instruction this cycle
- instr  in  16  instruction word
- rf_addr_a  out  3  register-file read address A (rs1) = D-stage rs1, combinational from D registers
- rf_addr_b  out  3  register-file read address B (rs2) = D-stage rs2, combinational
- rf_data_a  in  16  value of rf_addr_a, same cycle (asynchronous register file)
- rf_data_b  in  16  value of rf_addr_b, same cycle
- ex_valid  out  1  E-stage outputs hold a valid instruction
- ex_class  out  2  instruction class
- ex_result  out  16  ALU result; also the memory address for load/store
- ex_rd  out  3  destination register
- ex_reg_write  out  1  register write-back enable
- ex_wb_sel  out  1  write-back source: 1 = memory data, 0 = ex_result
- ex_mem_write  out  1  memory store enable
- ex_store_data  out  16  store data (rs2 value)
- ex_pc_write  out  1  branch taken
- ex_jump_target  out  16  absolute jump target (rs2 value)

Behaviour:

Encoding (class = instr[15:14]):
- 01 ALU R-type, instr[13]=0:
  - op=[12:9], rd=[8:6], rs1=[5:3], rs2=[2:0]
  - B = rs2 value
- 01 ALU I-type, instr[13]=1:
  - op=[12:9], rd=[8:6], rs1=rd
  - B = sign-extended [5:0]; rs2=0
- 00 memory: op forced to ADD, B = sign-extended [2:0], rs1=[5:3]
  - instr[13]=0 load: rd=[8:6], reg_write=1, wb_sel=1
  - instr[13]=1 store: rs2=[8:6], mem_write=1, reg_write=0
- 10 jump: jump_ctrl=[13:11], rs1=[5:3] (test), rs2=[2:0] (target); no register or memory write.
- 11: NOP; all enables 0.

ALU, 5-bit alu_ctrl = {0, op}, A = rs1 value, 16-bit results with carry discarded:
- 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A
- 6 SHL A by B[3:0], 7 SHR logical, 8 SRA
- 9 SLT signed (1/0), 10 SLTU, 11 pass B
- 12..31 result 0

Jump condition on test value T (signed), per jump_ctrl:
- 0 never, 1 always
- 2 T==0, 3 T!=0
- 4 T<0, 5 T>0, 6 T>=0, 7 T<=0
- ex_pc_write is forced to 0 unless class==10.

Timing:
- Cycle n: instr and in_valid are sampled into the D registers.
- Cycle n+1: rf_addr_a/b reflect the D fields; rf_data_a/b are used combinationally; E registers load at the end of n+1.
- E outputs are valid for one cycle, latency 2. New instruction accepted every cycle; no stall.

Valid and reset:
- in_valid=0 produces a bubble: D valid=0, and next cycle ex_valid=0 with ex_reg_write, ex_mem_write and ex_pc_write all 0. Data outputs are don't-care but deterministic; the required value is 0.
- rst: all D and E registers clear to 0, so every output is 0 and rf_addr_a/b are 0.
- Reset asserted mid-operation discards in-flight instructions. The first valid E output appears 2 cycles after the first valid instr following deassertion.

Test Plan:
- R-type ADD: instr 0x40CA (rd=3, rs1=1, rs2=2), rf_data_a=5, rf_data_b=7 -> rf_addr_a=1, rf_addr_b=2 in cycle n+1; at E: ex_result=12, ex_rd=3, ex_reg_write=1, ex_wb_sel=0, ex_mem_write=0.
- I-type SUB: instr 0x62BF (rd=rs1=2, imm=-1), rf_data_a=10 -> ex_result=11, ex_rd=2. Same encoding with op=8 (SRA, 0x70BF-style), A=0xFF00, imm=4 -> 0xFFF0. SLT with A=0x8000, B=1 -> 1; SLTU with the same operands -> 0.
- Store: instr 0x210E (rs1=1, rs2=4, imm=-2), rf_data_a=0x0100, rf_data_b=0xBEEF -> ex_result=0x00FE, ex_mem_write=1, ex_store_data=0xBEEF, ex_reg_write=0. Load 0x010E -> ex_reg_write=1, ex_wb_sel=1, ex_rd=4.
- Jump-if-zero: instr 0x900A, rf_data_a=0, rf_data_b=0x0040 -> ex_pc_write=1, ex_jump_target=0x0040.
  - rf_data_a=1 -> ex_pc_write=0.
  - jump_ctrl=4 with T=0x8000 -> taken.
  - jump_ctrl=0 -> never taken.
- Back-to-back stream of 4 instructions with a bubble (in_valid=0) in slot 3 -> results emerge on consecutive cycles, each 2 cycles after its input; the bubble slot has ex_valid=0 and all enables 0.
- Reset asserted while 2 instructions are in flight -> all outputs 0 immediately (asynchronous); no stale write enables after release.
